pipe_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline. It produces the per-stage `halt_type` and `*_discard` controls that the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb) consume. It arbitrates four hazard sources: memory-stage wait, taken branch/jump, load-use, and fetch wait. It holds a pending flush across memory freezes and counts stall cycles for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: halt encodings, controller states, address widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int InstAddrW = 32;

    typedef logic [InstAddrW-1:0] InstAddrBus;
    localparam InstAddrBus ZeroWord = '0;

    // Per-stage halt type consumed by every pipeline register.
    typedef logic [1:0] HaltBus;
    localparam HaltBus HALT_RUN    = 2'b00;  // advance
    localparam HaltBus HALT_PASS   = 2'b01;  // advance while upstream holds
    localparam HaltBus HALT_BUBBLE = 2'b10;  // load NOP
    localparam HaltBus HALT_HOLD   = 2'b11;  // keep value

    typedef enum logic [1:0] {
        PC_RUN       = 2'b00,
        PC_MEMWAIT   = 2'b01,
        PC_FLUSHPEND = 2'b10
    } pc_state_t;

    // Complete control word driven to the five pipeline registers.
    typedef struct packed {
        HaltBus pc;
        HaltBus ifid;
        HaltBus idex;
        HaltBus exmem;
        HaltBus memwb;
        logic   ifid_discard;
        logic   idex_discard;
        logic   redirect;
    } halt_ctrl_t;

    // BUBBLE and HOLD both have the upper bit set; either one is a stall cycle.
    function automatic logic halt_is_stall(input HaltBus h);
        return h[1];
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Latency: q reflects en one clock after the enabling edge.
// Backpressure: none; en is sampled every cycle.
//
// Ports: clk, rst (async active-low), en (count this cycle), q (count value).
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en && (q != CNT_MAX)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: arbitrates MEM wait, flush, load-use, fetch wait.
// Latency: all controls are combinational (same-cycle); state, latched target and counter update on clk.
// Backpressure: a MEM wait freezes everything and defers any taken branch until the wait drops.
//
// Ports:
//   clk, rst             clock and asynchronous active-low reset
//   if_stall_i           fetch waiting on memory
//   mem_stall_i          MEM-stage access waiting on memory
//   id_load_use_i        ID depends on the load in EX
//   ex_branch_i/target_i taken branch/jump resolved in EX and its target
//   *_halt_o             halt types for pc_reg, if_id, id_ex, ex_mem, mem_wb
//   IFID/IDEX_discard_o  clear if_id / id_ex
//   pc_redirect_o        pc_reg loads pc_target_o
//   stall_cnt_o          saturating count of cycles issuing any hold or bubble
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stall_i,
    input  logic             mem_stall_i,
    input  logic             id_load_use_i,
    input  logic             ex_branch_i,
    input  logic [31:0]      ex_target_i,
    output logic [1:0]       pc_halt_o,
    output logic [1:0]       ifid_halt_o,
    output logic [1:0]       idex_halt_o,
    output logic [1:0]       exmem_halt_o,
    output logic [1:0]       memwb_halt_o,
    output logic             IFID_discard_o,
    output logic             IDEX_discard_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_target_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    pc_state_t  state_q, state_d;
    InstAddrBus tgt_q, tgt_d;
    halt_ctrl_t ctrl;
    InstAddrBus target;
    logic       flush_req;
    logic       stall_cycle;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_RUN;
            tgt_q   <= ZeroWord;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // A branch seen during a MEM wait cannot redirect yet (the whole pipe is
    // frozen), so its target is captured and replayed when the wait ends.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        case (state_q)
            PC_RUN, PC_MEMWAIT: begin
                if (mem_stall_i) begin
                    if (ex_branch_i) begin
                        state_d = PC_FLUSHPEND;
                        tgt_d   = ex_target_i;
                    end else begin
                        state_d = PC_MEMWAIT;
                    end
                end else begin
                    state_d = PC_RUN;
                end
            end
            PC_FLUSHPEND: begin
                // The branch is still parked in EX; re-assertions of
                // ex_branch_i are the same branch and are ignored.
                if (!mem_stall_i) begin
                    state_d = PC_RUN;
                end
            end
            default: begin
                state_d = PC_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs, in priority order: MEM wait > flush > load-use > fetch.
    // id_ex has no hold capability, so a MEM freeze uses PASS there and relies
    // on ex_mem holding plus the upstream registers holding.
    // ------------------------------------------------------------------
    assign flush_req = ex_branch_i || (state_q == PC_FLUSHPEND);

    always_comb begin
        ctrl   = '{pc: HALT_RUN, ifid: HALT_RUN, idex: HALT_RUN,
                   exmem: HALT_RUN, memwb: HALT_RUN,
                   ifid_discard: 1'b0, idex_discard: 1'b0, redirect: 1'b0};
        target = (state_q == PC_FLUSHPEND) ? tgt_q : ex_target_i;

        if (!rst) begin
            ctrl   = '{pc: HALT_BUBBLE, ifid: HALT_BUBBLE, idex: HALT_BUBBLE,
                       exmem: HALT_BUBBLE, memwb: HALT_BUBBLE,
                       ifid_discard: 1'b1, idex_discard: 1'b1, redirect: 1'b0};
            target = ZeroWord;
        end else if (mem_stall_i) begin
            ctrl.pc    = HALT_HOLD;
            ctrl.ifid  = HALT_HOLD;
            ctrl.idex  = HALT_PASS;
            ctrl.exmem = HALT_HOLD;
            ctrl.memwb = HALT_BUBBLE;
        end else if (flush_req) begin
            ctrl.redirect     = 1'b1;
            ctrl.ifid_discard = 1'b1;
            ctrl.idex_discard = 1'b1;
            ctrl.ifid         = HALT_BUBBLE;
            ctrl.idex         = HALT_BUBBLE;
        end else if (id_load_use_i || if_stall_i) begin
            // Load-use and fetch wait share one pattern: freeze the front end
            // and let the back end drain behind a bubble.
            ctrl.pc   = HALT_HOLD;
            ctrl.ifid = HALT_HOLD;
            ctrl.idex = HALT_BUBBLE;
        end
    end

    assign pc_halt_o      = ctrl.pc;
    assign ifid_halt_o    = ctrl.ifid;
    assign idex_halt_o    = ctrl.idex;
    assign exmem_halt_o   = ctrl.exmem;
    assign memwb_halt_o   = ctrl.memwb;
    assign IFID_discard_o = ctrl.ifid_discard;
    assign IDEX_discard_o = ctrl.idex_discard;
    assign pc_redirect_o  = ctrl.redirect;
    assign pc_target_o    = target;

    // ------------------------------------------------------------------
    // Performance counter: any stage told to bubble or hold is a lost cycle.
    // ------------------------------------------------------------------
    assign stall_cycle = halt_is_stall(ctrl.pc)    || halt_is_stall(ctrl.ifid) ||
                         halt_is_stall(ctrl.idex)  || halt_is_stall(ctrl.exmem) ||
                         halt_is_stall(ctrl.memwb);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall_cycle),
        .q   (stall_cnt_o)
    );

endmodule
